instr_encoder: RTL

- Pipelined RV32I instruction encoder: packs opcode, register fields, funct3 and a 32-bit immediate into a 32-bit instruction word.
- It is the inverse of the immediate generator in the decode path. For every in-range immediate, decoding the emitted word returns the original immediate.
- It sits between the test-program loader and instruction memory. Upstream and downstream each use a valid/ready handshake.
- It also flags immediates that are not representable, and keeps encode and error counts.

---
 rtl/instr_encoder.sv | 96 +++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I I/S/B instruction packer with valid/ready handshakes,
// immediate range checking and encode/error counters.
module instr_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  logic        s1_valid;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_f3;
  logic [31:0] s1_imm;
  logic        s1_adv, in_fire, out_fire;
  logic        is_i, is_s, is_b, fit12, fit13, bad;
  logic [31:0] word;
  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // fit12/fit13: upper bits are pure sign extension of a 12-/13-bit immediate
  always_comb begin
    is_i  = s1_op == OP_IMM || s1_op == LOAD;
    is_s  = s1_op == STORE;
    is_b  = s1_op == BRANCH;
    fit12 = &s1_imm[31:11] || ~|s1_imm[31:11];
    fit13 = &s1_imm[31:12] || ~|s1_imm[31:12];
    bad   = (is_i || is_s) ? !fit12 : is_b ? (!fit13 || s1_imm[0]) : 1'b1;
    word  = is_i ? {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op} :
            is_s ? {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op} :
                   {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11], s1_op};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_f3    <= '0;
      s1_imm   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= in_opcode;
      s1_rd    <= in_rd;
      s1_rs1   <= in_rs1;
      s1_rs2   <= in_rs2;
      s1_f3    <= in_funct3;
      s1_imm   <= in_imm;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_instr <= bad ? NOP : word;
      out_err   <= bad;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_fire) begin
      enc_count <= enc_count + CNT_W'(1);
      err_count <= (out_err && err_count != '1) ? err_count + ERR_W'(1) : err_count;
    end
  end
endmodule
